// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: single-clock FIFO with count-based flags, sticky errors and registered or FWFT read
module sync_fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = 12,
  parameter int AE_LEVEL   = 4,
  parameter int FWFT       = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         w_en,
  input  logic [DATA_WIDTH-1:0]        data_in,
  input  logic                         r_en,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic                         rd_valid,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow,
  output logic                         underflow,
  input  logic                         clr_err
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] w_ptr, r_ptr;
  logic wr_acc, rd_acc;
  assign full         = count == CW'(DEPTH);
  assign empty        = count == '0;
  assign almost_full  = count >= CW'(AF_LEVEL);
  assign almost_empty = count <= CW'(AE_LEVEL);
  assign wr_acc       = w_en & ~full;
  assign rd_acc       = r_en & ~empty;
  // pointers, fill level and sticky error flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_ptr     <= '0;
      r_ptr     <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) w_ptr <= (w_ptr == PW'(DEPTH-1)) ? '0 : w_ptr + 1'b1;
      if (rd_acc) r_ptr <= (r_ptr == PW'(DEPTH-1)) ? '0 : r_ptr + 1'b1;
      count     <= count + CW'(wr_acc) - CW'(rd_acc);
      overflow  <= (w_en & full) | (overflow & ~clr_err);
      underflow <= (r_en & empty) | (underflow & ~clr_err);
    end
  end
  // storage is not reset; writes during reset are dropped
  always_ff @(posedge clk) begin
    if (rst_n && wr_acc) mem[w_ptr] <= data_in;
  end
  generate
    if (FWFT != 0) begin : g_fwft
      assign data_out = mem[r_ptr];
      assign rd_valid = ~empty;
    end else begin : g_reg
      // registered read: data_out holds its last value between pops
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          data_out <= '0;
          rd_valid <= 1'b0;
        end else begin
          rd_valid <= rd_acc;
          if (rd_acc) data_out <= mem[r_ptr];
        end
      end
    end
  endgenerate
endmodule
